// File: rtl/conv_pe_pkg.sv
// conv_pe_pkg: shared state encoding, defaults and int8 saturation for the pixel engine
package conv_pe_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_POST1, S_POST2, S_OUT} pe_state_t;
  localparam int SCALE_Q_DEF     = 16;
  localparam int LEAKY_MUL_DEF   = 13;
  localparam int LEAKY_SHIFT_DEF = 7;
  function automatic logic [7:0] sat_int8(input logic signed [48:0] v);
    return v > 49'sd127 ? 8'h7f : v < -49'sd128 ? 8'h80 : v[7:0];
  endfunction
endpackage

// File: rtl/pe_post_lane.sv
// pe_post_lane: bias add + LeakyReLU stage, then rounded requantize to saturated int8
module pe_post_lane
  import conv_pe_pkg::*;
#(
  parameter int SCALE_Q     = SCALE_Q_DEF,
  parameter int LEAKY_MUL   = LEAKY_MUL_DEF,
  parameter int LEAKY_SHIFT = LEAKY_SHIFT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_y,
  input  logic        ld_q,
  input  logic [31:0] acc,
  input  logic [31:0] bias,
  input  logic [15:0] scale,
  output logic [7:0]  q_out
);
  logic signed [31:0] s, y_d, y_q;
  logic signed [39:0] m;
  logic signed [48:0] p;
  logic [7:0] q_d, q_q;
  always_comb begin
    s   = acc + bias;
    m   = 40'(s) * 40'(LEAKY_MUL);
    y_d = ld_y ? (s[31] ? 32'(m >>> LEAKY_SHIFT) : s) : y_q;
    p   = 49'(y_q) * $signed({33'd0, scale}) + (49'sd1 <<< (SCALE_Q - 1));
    q_d = ld_q ? sat_int8(p >>> SCALE_Q) : q_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      q_q <= '0;
    end else begin
      y_q <= y_d;
      q_q <= q_d;
    end
  end
  assign q_out = q_q;
endmodule

// File: rtl/conv_pixel_engine.sv
// conv_pixel_engine: streaming NUM_CH-lane int8 MAC with bias, LeakyReLU and requantize
module conv_pixel_engine
  import conv_pe_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int K_MAX       = 4608,
  parameter int SCALE_Q     = SCALE_Q_DEF,
  parameter int LEAKY_MUL   = LEAKY_MUL_DEF,
  parameter int LEAKY_SHIFT = LEAKY_SHIFT_DEF,
  localparam int KW         = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic [15:0]            scale,
  input  logic [NUM_CH*32-1:0]   bias,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [7:0]      act,
  input  logic [NUM_CH*8-1:0]    wt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CH*8-1:0]    out_data,
  output logic                   busy
);
  pe_state_t state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d, cnt_q, cnt_d;
  logic [15:0] scale_q, scale_d;
  logic [NUM_CH*32-1:0] bias_q, bias_d, acc_q, acc_d;
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    scale_d = scale_q;
    bias_d  = bias_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: if (start) begin
        k_len_d = k_len;
        scale_d = scale;
        bias_d  = bias;
        cnt_d   = '0;
        acc_d   = '0;
        state_d = k_len == '0 ? S_POST1 : S_ACCUM;
      end
      S_ACCUM: if (in_valid) begin
        for (int c = 0; c < NUM_CH; c++)
          acc_d[32*c+:32] = acc_q[32*c+:32] + 32'(act) * 32'($signed(wt[8*c+:8]));
        cnt_d = cnt_q + KW'(1);
        if (cnt_q == k_len_q - KW'(1)) state_d = S_POST1;
      end
      S_POST1: state_d = S_POST2;
      S_POST2: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_len_q <= '0;
      scale_q <= '0;
      bias_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      scale_q <= scale_d;
      bias_q  <= bias_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end
  assign in_ready  = state_q == S_ACCUM;
  assign out_valid = state_q == S_OUT;
  assign busy      = state_q != S_IDLE;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    pe_post_lane #(
      .SCALE_Q    (SCALE_Q),
      .LEAKY_MUL  (LEAKY_MUL),
      .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .ld_y (state_q == S_POST1),
      .ld_q (state_q == S_POST2),
      .acc  (acc_q[32*g+:32]),
      .bias (bias_q[32*g+:32]),
      .scale(scale_q),
      .q_out(out_data[8*g+:8])
    );
  end
endmodule

// File: tb/tb_conv_pixel_engine.sv
// tb_conv_pixel_engine: randomized pixels checked against an integer reference model
module tb_conv_pixel_engine;
  localparam int NC = 4, KMAX = 4608, KW = $clog2(KMAX + 1), AMAX = 600;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [KW-1:0] k_len = '0;
  logic [15:0] scale = '0;
  logic [NC*32-1:0] bias = '0;
  logic signed [7:0] act = '0;
  logic [NC*8-1:0] wt = '0;
  logic in_ready, out_valid, busy;
  logic [NC*8-1:0] out_data;
  int checks = 0, errors = 0;
  int k_cur, sc_cur;
  int act_a[AMAX];
  int wt_a[AMAX][NC];
  int bias_a[NC];

  conv_pixel_engine #(.NUM_CH(NC), .K_MAX(KMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .scale(scale), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .act(act), .wt(wt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NC*8-1:0] model();
    logic [NC*8-1:0] r;
    int acc;
    longint y, p, q;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      acc = 0;
      for (int i = 0; i < k_cur; i++) acc += act_a[i] * wt_a[i][c];
      acc += bias_a[c];
      y = acc >= 0 ? longint'(acc) : (longint'(acc) * 13) >>> 7;
      p = y * longint'(sc_cur) + 32768;
      q = p >>> 16;
      q = q > 127 ? 127 : q < -128 ? -128 : q;
      r[8*c+:8] = 8'(q);
    end
    return r;
  endfunction

  task automatic rand_vec(input int k);
    for (int i = 0; i < k; i++) begin
      act_a[i] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < NC; c++) wt_a[i][c] = int'($urandom_range(0, 255)) - 128;
    end
    for (int c = 0; c < NC; c++) bias_a[c] = int'($urandom_range(0, 2097152)) - 1048576;
  endtask

  task automatic start_pixel(input int k, input int sc);
    k_cur = k;
    sc_cur = sc;
    k_len = KW'(k);
    scale = 16'(sc);
    for (int c = 0; c < NC; c++) bias[32*c+:32] = 32'(bias_a[c]);
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic feed(input bit gaps, output bit ready_ok);
    ready_ok = 1;
    for (int i = 0; i < k_cur; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        in_valid = 0;
        act = 8'($urandom);
        wt = NC*8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1;
      act = 8'(act_a[i]);
      for (int c = 0; c < NC; c++) wt[8*c+:8] = 8'(wt_a[i][c]);
      if (in_ready !== 1'b1) ready_ok = 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    ok = out_valid === 1'b1;
  endtask

  task automatic ack();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_data} !== '0) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b busy=%b data=%h exp all 0", in_ready, out_valid, busy, out_data);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [NC*8-1:0] exp_v;
    exp_v = {NC{8'd3}};
    for (int c = 0; c < NC; c++) begin
      wt_a[0][c] = 3;
      bias_a[c] = 0;
    end
    act_a[0] = 2;
    start_pixel(1, 32768);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start got rdy=%b busy=%b exp 1 1", in_ready, busy);
    end
    in_valid = 1;
    act = 8'sd2;
    wt = {NC{8'd3}};
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_latency_%0d got out_valid=%b exp 0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      errors++;
      $display("FAIL basic_result got vld=%b data=%h exp 1 %h", out_valid, out_data, exp_v);
    end
    ack();
  endtask

  task automatic test_leaky_sat();
    bit ok, rok;
    logic [NC*8-1:0] exp_v;
    exp_v = {8'h00, 8'h80, 8'h7f, 8'hfb};
    act_a[0] = 1;
    wt_a[0][0] = 0;    bias_a[0] = -100;
    wt_a[0][1] = 100;  bias_a[1] = 900;
    wt_a[0][2] = -128; bias_a[2] = -39872;
    wt_a[0][3] = 5;    bias_a[3] = -5;
    start_pixel(1, 32768);
    feed(0, rok);
    wait_out(ok);
    checks++;
    if (!ok || !rok || out_data !== exp_v) begin
      errors++;
      $display("FAIL leaky_sat got ok=%b rdy=%b data=%h exp %h", ok, rok, out_data, exp_v);
    end
    ack();
  endtask

  task automatic test_golden();
    bit ok, rok;
    logic [NC*8-1:0] r1;
    rand_vec(576);
    start_pixel(576, 655);
    feed(0, rok);
    wait_out(ok);
    r1 = out_data;
    checks++;
    if (!ok || !rok || r1 !== model()) begin
      errors++;
      $display("FAIL golden_dense got ok=%b rdy=%b data=%h exp %h", ok, rok, r1, model());
    end
    ack();
    start_pixel(576, 655);
    feed(1, rok);
    wait_out(ok);
    checks++;
    if (!ok || !rok || out_data !== model() || out_data !== r1) begin
      errors++;
      $display("FAIL golden_gaps got ok=%b rdy=%b data=%h exp %h", ok, rok, out_data, model());
    end
    ack();
  endtask

  task automatic test_backpressure();
    bit ok, rok;
    logic [NC*8-1:0] held;
    rand_vec(3);
    start_pixel(3, $urandom_range(1, 65535));
    feed(0, rok);
    wait_out(ok);
    held = out_data;
    checks++;
    if (!ok || !rok || held !== model()) begin
      errors++;
      $display("FAIL bp_result got ok=%b rdy=%b data=%h exp %h", ok, rok, held, model());
    end
    for (int i = 0; i < 5; i++) begin
      start = i == 1;
      k_len = KW'(7);
      @(posedge clk); #1;
      start = 0;
      checks++;
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d got data=%h vld=%b rdy=%b busy=%b exp %h 1 0 1", i, out_data, out_valid, in_ready, busy, held);
      end
    end
    ack();
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle got busy=%b vld=%b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_zero_len();
    bit rdy_seen;
    logic [NC*8-1:0] exp_v;
    exp_v = {NC{8'd100}};
    for (int c = 0; c < NC; c++) bias_a[c] = 200;
    in_valid = 1;
    act = 8'sd5;
    wt = {NC{8'd7}};
    start_pixel(0, 32768);
    rdy_seen = 0;
    for (int i = 0; i < 2; i++) begin
      rdy_seen |= in_ready;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_latency_%0d got out_valid=%b exp 0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    rdy_seen |= in_ready;
    in_valid = 0;
    checks++;
    if (rdy_seen || out_valid !== 1'b1 || out_data !== exp_v) begin
      errors++;
      $display("FAIL zero_len got rdy_seen=%b vld=%b data=%h exp 0 1 %h", rdy_seen, out_valid, out_data, exp_v);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    bit ok, rok;
    rand_vec(10);
    start_pixel(10, 40000);
    in_valid = 1;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 0;
    #2;
    checks++;
    if ({in_ready, out_valid, busy, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b busy=%b data=%h exp all 0", in_ready, out_valid, busy, out_data);
    end
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    rand_vec(6);
    start_pixel(6, 20000);
    feed(0, rok);
    wait_out(ok);
    checks++;
    if (!ok || !rok || out_data !== model()) begin
      errors++;
      $display("FAIL reset_clean got ok=%b rdy=%b data=%h exp %h", ok, rok, out_data, model());
    end
    ack();
  endtask

  task automatic test_random();
    bit ok, rok, early;
    for (int n = 0; n < 8; n++) begin
      rand_vec($urandom_range(1, 24));
      early = 1'($urandom_range(0, 1));
      out_ready = early;
      start_pixel($urandom_range(1, 24), $urandom_range(1, 65535));
      feed(1'($urandom_range(0, 1)), rok);
      wait_out(ok);
      checks++;
      if (!ok || !rok || out_data !== model()) begin
        errors++;
        $display("FAIL random_%0d got ok=%b rdy=%b data=%h exp %h", n, ok, rok, out_data, model());
      end
      if (!early) repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leaky_sat();
    test_golden();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
